// File: rtl/mem_ls_pkg.sv
// mem_ls shared definitions: load/store opcodes, FSM states,
// access-length helpers and reset/zero constants.
package mem_ls_pkg;

    typedef enum logic [2:0] {
        LS_LB  = 3'b000,
        LS_LH  = 3'b001,
        LS_LW  = 3'b010,
        LS_SB  = 3'b011,
        LS_LBU = 3'b100,
        LS_LHU = 3'b101,
        LS_SH  = 3'b110,
        LS_SW  = 3'b111
    } ls_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;

    // Index of the last byte of an access (length - 1).
    function automatic logic [1:0] ls_last(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            LS_LB, LS_LBU, LS_SB: r = 2'd0;
            LS_LH, LS_LHU, LS_SH: r = 2'd1;
            default:              r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic ls_is_store(input logic [2:0] op);
        logic r;
        case (op)
            LS_SB, LS_SH, LS_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ls_extend.sv
// ls_extend: sign/zero extension of assembled load data.
// Ports: op (load opcode), raw (assembled bytes), ext (result).
module ls_extend
    import mem_ls_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (op)
            LS_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            LS_LBU:  ext = {24'h0, raw[7:0]};
            LS_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            LS_LHU:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ls.sv
// mem_ls: MEM stage; serialises loads/stores into byte requests.
// Ports: clk, rst (sync, active-high); EX/MEM inputs wd_i, wreg_i,
// wdata_i, ls_valid_i, ls_op_i, ls_addr_i, ls_sdata_i; byte bus
// mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_ack_i/mem_rdata_i;
// MEM/WB outputs wd_o, wreg_o, wdata_o; stall_req_o; misalign_o.
// Option: define MEM_LS_ALIGN_CHECK_EN to reject misaligned H/W.
module mem_ls
    import mem_ls_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ls_valid_i,
    input  logic [2:0]        ls_op_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_sdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req_o,
    output logic              misalign_o
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] buf_q;
    logic [4:0]        rd_q;
    logic [1:0]        cnt_q;
    logic              misalign;
    logic              start;
    logic              last;
    logic              store_q;
    logic [DATA_W-1:0] ext;

    ls_extend u_ext (
        .op  (op_q),
        .raw (buf_q),
        .ext (ext)
    );

`ifdef MEM_LS_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (ls_op_i)
            LS_LH, LS_LHU, LS_SH: misalign = ls_addr_i[0];
            LS_LW, LS_SW:         misalign = |ls_addr_i[1:0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign start   = (state_q == S_IDLE) && ls_valid_i && !misalign;
    assign last    = (cnt_q == ls_last(op_q));
    assign store_q = ls_is_store(op_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACCESS;
            S_ACCESS: if (mem_ack_i && last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= '0;
            sdata_q <= ZeroWord;
            buf_q   <= ZeroWord;
            rd_q    <= 5'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q    <= ls_op_i;
                addr_q  <= ls_addr_i;
                sdata_q <= ls_sdata_i;
                rd_q    <= wd_i;
                cnt_q   <= 2'd0;
                buf_q   <= ZeroWord;
            end else if (state_q == S_ACCESS && mem_ack_i) begin
                if (!store_q)
                    buf_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
                if (!last)
                    cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ls_valid_i) begin
                    wreg_o      = 1'b0;
                    misalign_o  = misalign;
                    stall_req_o = !misalign;
                end
            end
            S_ACCESS: begin
                mem_req_o   = 1'b1;
                mem_we_o    = store_q;
                mem_addr_o  = addr_q + ADDR_W'(cnt_q);
                mem_wdata_o = sdata_q[{cnt_q, 3'b000} +: 8];
                wd_o        = rd_q;
                wreg_o      = 1'b0;
                stall_req_o = 1'b1;
            end
            S_DONE: begin
                wd_o    = rd_q;
                wreg_o  = !store_q;
                wdata_o = store_q ? ZeroWord : ext;
            end
            default: ;
        endcase
        // Reset cycle forces every output low, aborting any access.
        if (rst == RstEnable) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = 8'h00;
            wd_o        = 5'd0;
            wreg_o      = 1'b0;
            wdata_o     = ZeroWord;
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
        end
    end

endmodule
